// File: rtl/add7_feeder.sv
// Front-end for the seven-operand add kernel: packs seven streamed operands into
// the kernel inputs, launches it, and returns its result (or a timeout) as a stream.
module add7_feeder #(
  parameter int unsigned TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [63:0] s_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [63:0] m_data,
  output logic        m_error,
  output logic        busy,
  output logic        k_r_enable,
  output logic [63:0] k_init_a,
  output logic [63:0] k_init_b,
  output logic [63:0] k_init_c,
  output logic [63:0] k_init_d,
  output logic [63:0] k_init_e,
  output logic [63:0] k_init_f,
  output logic [63:0] k_init_g,
  input  logic        k_w_enable,
  input  logic [63:0] k_result
);

  localparam int unsigned DW     = 64;
  localparam int unsigned NSLOT  = 7;
  localparam int unsigned IW     = 3;
  localparam int unsigned CW     = $clog2(TIMEOUT);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_LAUNCH  = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  logic [1:0]    state, state_nxt;
  logic [IW-1:0] idx, idx_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [DW-1:0] data_nxt;
  logic          err_nxt;
  logic          load;
  logic [DW-1:0] slot [NSLOT];

  assign load = (state == S_COLLECT) && s_valid && s_ready;

  // Next-state, counters and captured response
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    data_nxt  = m_data;
    err_nxt   = m_error;
    case (state)
      S_COLLECT: begin
        if (load) begin
          if (idx == IW'(NSLOT - 1)) begin
            idx_nxt   = '0;
            state_nxt = S_LAUNCH;
          end else begin
            idx_nxt = idx + IW'(1);
          end
        end
      end
      S_LAUNCH: begin
        cnt_nxt   = '0;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        // success wins over a coincident timeout
        if (k_w_enable) begin
          data_nxt  = k_result;
          err_nxt   = 1'b0;
          state_nxt = S_RESP;
        end else if (cnt == CW'(TIMEOUT - 1)) begin
          data_nxt  = '0;
          err_nxt   = 1'b1;
          state_nxt = S_RESP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      S_RESP: begin
        if (m_valid && m_ready) state_nxt = S_COLLECT;
      end
      default: state_nxt = S_COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_COLLECT;
      idx        <= '0;
      cnt        <= '0;
      m_data     <= '0;
      m_error    <= 1'b0;
      s_ready    <= 1'b0;
      m_valid    <= 1'b0;
      k_r_enable <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      cnt        <= cnt_nxt;
      m_data     <= data_nxt;
      m_error    <= err_nxt;
      s_ready    <= (state_nxt == S_COLLECT);
      m_valid    <= (state_nxt == S_RESP);
      k_r_enable <= (state_nxt == S_LAUNCH);
      busy       <= !((state_nxt == S_COLLECT) && (idx_nxt == '0));
    end
  end

  // Operand slots keep their contents between jobs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSLOT; i++) slot[i] <= '0;
    end else begin
      for (int i = 0; i < NSLOT; i++) begin
        if (load && (idx == IW'(i))) slot[i] <= s_data;
      end
    end
  end

  assign k_init_a = slot[0];
  assign k_init_b = slot[1];
  assign k_init_c = slot[2];
  assign k_init_d = slot[3];
  assign k_init_e = slot[4];
  assign k_init_f = slot[5];
  assign k_init_g = slot[6];

endmodule
